// File: rtl/hs_npu_result_deskewer_if.sv
// Result-side bus of the deskewer: staggered per-column results in,
// aligned rows out with a valid/ready handshake.
interface hs_npu_result_deskewer_if #(
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_COLS-1:0]            col_valid_in;
   logic [NUM_COLS*DATA_WIDTH-1:0] col_data_in;
   logic                           row_valid_out;
   logic [NUM_COLS*DATA_WIDTH-1:0] row_data_out;
   logic                           row_ready_in;

   modport master (
      output col_valid_in, col_data_in, row_ready_in,
      input  row_valid_out, row_data_out
   );

   modport slave (
      input  col_valid_in, col_data_in, row_ready_in,
      output row_valid_out, row_data_out
   );
endinterface

// File: rtl/hs_npu_result_deskewer.sv
// Removes the one-cycle-per-lane skew from systolic-array results, buffers the
// aligned rows in a first-word-fall-through FIFO and reports completion.
module hs_npu_result_deskewer #(
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_in,
   input  logic [31:0]               rows_in,
   hs_npu_result_deskewer_if.slave   bus,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic                      misalign
);
   localparam int RW = NUM_COLS * DATA_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     rows_rem_q, rows_rem_d;
   logic            ovf_q, ovf_d;
   logic            mis_q, mis_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   mem_q [FIFO_DEPTH];

   logic [NUM_COLS-1:0] dly_valid_s;
   logic [RW-1:0]       dly_data_s;
   logic                aligned_s, partial_s, full_s, pop_s, push_s;

   // Column c is delayed by NUM_COLS-1-c stages so all lanes of a row meet.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int DLY = NUM_COLS - 1 - c;
      if (DLY == 0) begin : g_pass
         assign dly_valid_s[c] = bus.col_valid_in[c];
         assign dly_data_s[c*DATA_WIDTH +: DATA_WIDTH] = bus.col_data_in[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_stage
         logic [DLY-1:0]                 v_q;
         logic [DLY-1:0][DATA_WIDTH-1:0] d_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= '0;
               d_q <= '0;
            end else begin
               v_q[0] <= bus.col_valid_in[c];
               d_q[0] <= bus.col_data_in[c*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < DLY; k++) begin
                  v_q[k] <= v_q[k-1];
                  d_q[k] <= d_q[k-1];
               end
            end
         end
         assign dly_valid_s[c] = v_q[DLY-1];
         assign dly_data_s[c*DATA_WIDTH +: DATA_WIDTH] = d_q[DLY-1];
      end
   end

   assign aligned_s = &dly_valid_s;
   assign partial_s = (|dly_valid_s) & ~aligned_s;
   assign full_s    = (cnt_q == CW'(FIFO_DEPTH));
   assign pop_s     = (cnt_q != CW'(0)) && bus.row_ready_in;
   // A push at full is still accepted when a pop frees the head slot.
   assign push_s    = (state_q == ST_COLLECT) && aligned_s && (!full_s || pop_s);

   always_comb begin
      state_d    = state_q;
      rows_rem_d = rows_rem_q;
      ovf_d      = ovf_q;
      mis_d      = mis_q;
      wr_ptr_d   = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               rows_rem_d = rows_in;
               ovf_d      = 1'b0;
               mis_d      = 1'b0;
               state_d    = (rows_in == 32'd0) ? ST_DONE : ST_COLLECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (partial_s) begin
               mis_d = 1'b1;
            end else begin
               mis_d = mis_q;
            end
            // Dropped rows still count so the collection always terminates.
            if (aligned_s) begin
               rows_rem_d = rows_rem_q - 32'd1;
               if (!push_s) begin
                  ovf_d = 1'b1;
               end else begin
                  ovf_d = ovf_q;
               end
               if (rows_rem_q == 32'd1) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_COLLECT;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (cnt_d == CW'(0)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rows_rem_q <= 32'd0;
         ovf_q      <= 1'b0;
         mis_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rows_rem_q <= rows_rem_d;
         ovf_q      <= ovf_d;
         mis_q      <= mis_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= dly_data_s;
      end
   end

   assign bus.row_valid_out = (cnt_q != CW'(0));
   assign bus.row_data_out  = (cnt_q != CW'(0)) ? mem_q[rd_ptr_q] : '0;
   assign busy              = (state_q != ST_IDLE);
   assign done              = (state_q == ST_DONE);
   assign overflow          = ovf_q;
   assign misalign          = mis_q;
endmodule
